wave_voice_scheduler: RTL and testbench
=======================================

Name: wave_voice_scheduler

Overview:
- Time-multiplexes one combinational sine ROM (index/freq_id in, value/freq out) across NUM_VOICES keyboard voices.
- On each sample request, walks every voice in turn and looks up |sine| at that voice's phase.
- Sums the looked-up amplitudes and advances each active voice's phase accumulator by its key's scaled frequency.
- Sits between the keyboard/note logic and the wave renderer; the ROM instance lives at the parent level and is wired to the rom_* ports.

Parameters:
- NUM_VOICES, 4, number of voices sharing the ROM (1..8).
- PHASE_FRAC, 8, fractional bits in each phase accumulator. ROM freq 256 advances the index by exactly 1 per sample.
- SUM_W, 12, width of sample_out. Must satisfy SUM_W >= 10 + clog2(NUM_VOICES).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_req  in  1  one-cycle pulse requesting one summed sample
- phase_clear  in  1  zero all phase accumulators; aborts any sample in progress
- voice_active  in  NUM_VOICES  per-voice enable
- voice_freq_id  in  5*NUM_VOICES  key id per voice; voice v occupies bits [5v+4:5v]
- rom_index  out  11  ROM index; equals {1'b0, phase[v][PHASE_FRAC+9:PHASE_FRAC]}
- rom_freq_id  out  5  ROM key id for the voice currently being evaluated
- rom_value  in  10  ROM amplitude, 0..768
- rom_freq  in  11  ROM scaled frequency, 0 for an invalid id
- busy  out  1  high while a sample is in progress
- sample_valid  out  1  one-cycle pulse when sample_out is updated
- sample_out  out  SUM_W  sum of active-voice amplitudes

Behaviour:
- Reset (async) values:
  - outputs: busy=0, sample_valid=0, sample_out=0, rom_index=0, rom_freq_id=0
  - internal: all phases=0, voice counter vcnt=0, state=IDLE
- Phase accumulator: PHASE_FRAC+10 bits per voice. It wraps naturally mod 1024 index units.
- FSM states: IDLE, RUN.
- IDLE:
  - sample_req=1 with phase_clear=0 → snapshot voice_active and voice_freq_id, clear the accumulator, vcnt=0, go to RUN, busy=1 next cycle.
  - sample_req while busy=1 is ignored (dropped, not queued).
- RUN, voice vcnt (one cycle per voice):
  - rom_freq_id = snapshot id[vcnt]; rom_index = phase[vcnt] integer part. Both are combinational from registers.
  - A voice is effective if active is set, id <= 24, and rom_freq != 0.
  - Effective voice: accumulator += rom_value, and phase[vcnt] += rom_freq.
  - Non-effective voice: contributes 0 and its phase holds.
  - When vcnt = NUM_VOICES-1: next cycle sample_out = final sum, sample_valid=1, busy=0, state=IDLE, vcnt=0.
- Latency:
  - Request accepted at cycle t → voice k evaluated at cycle t+1+k → sample_valid at t+1+NUM_VOICES.
  - A new sample_req is accepted in the same cycle that sample_valid is high. Maximum throughput is one sample per NUM_VOICES+1 cycles.
- phase_clear (highest priority, any state):
  - All phases go to 0 next cycle, state=IDLE, busy=0.
  - No sample_valid for an aborted sample; sample_out holds its previous value.
  - A sample_req in the same cycle is dropped.
- Input changes mid-sample have no effect; only the snapshot is used.
- sample_out holds between valid pulses.
- Sum cannot overflow when the SUM_W rule holds (max 768*NUM_VOICES).

Optional Feature:
- Macro: WAVE_VOICE_SCHED_PEAK_EN.
- When defined:
  - Adds output port peak_out [SUM_W-1:0], reset 0.
  - On each sample_valid, peak_out = max(peak_out, new sample_out).
  - phase_clear resets peak_out to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package wave_pkg holds:
  - NUM_KEYS=25, FREQ_ID_W=5, INDEX_W=11, VALUE_W=10, FREQ_W=11, DEFAULT_PHASE_FRAC=8
  - state enum {IDLE, RUN}
- Sub-module voice_phase_bank: NUM_VOICES phase registers with read port (vcnt), increment-write port, and synchronous clear.
- The FSM, snapshot registers and accumulator stay in the top module.

Test Plan:
- NUM_VOICES=4, only voice0 active with id 0 (ROM freq 256), three requests → sample_out 0, 5, 9; sample_valid at t+5 after each accepted request.
- Voice0 id 12 (ROM freq 512) alone, three samples → 0, 9, 19 (index steps 0, 2, 4).
- Voice0 id 0 plus voice1 id 24 (ROM freq 1024), two samples → 0, then 5+19=24; rom_index on the voice1 cycle is 0, then 4.
- Wrap-around: voice0 id 24 alone, 256 samples, then one more → rom_index returns to 0 and sample_out=0.
- Voice0 active with id 30 → sample_out 0 and phase unchanged. sample_req pulsed while busy=1 → no extra sample_valid.
- phase_clear during RUN (vcnt=2) → no sample_valid, busy=0 next cycle; next sample → 0. With WAVE_VOICE_SCHED_PEAK_EN, peak_out is 0 after the clear.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared constants and types for the wave voice scheduler and its phase bank.
package wave_pkg;

  localparam int NUM_KEYS           = 25;
  localparam int FREQ_ID_W          = 5;
  localparam int INDEX_W            = 11;
  localparam int VALUE_W            = 10;
  localparam int FREQ_W             = 11;
  localparam int DEFAULT_PHASE_FRAC = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/wave_voice_scheduler_voice_phase_bank.sv
// voice_phase_bank: one phase accumulator per voice.
// It has a single read port, one increment port and a synchronous clear.
// Each accumulator wraps naturally at its full width.
module voice_phase_bank
  import wave_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 18,
  parameter int INC_W      = FREQ_W,
  parameter int SEL_W      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [PHASE_W-1:0] rd_phase,
  input  logic               inc_en,
  input  logic [SEL_W-1:0]   inc_sel,
  input  logic [INC_W-1:0]   inc_val
);

  logic [PHASE_W-1:0] phase_q [NUM_VOICES];

  assign rd_phase = phase_q[rd_sel];

  // Phase registers: clear has priority over an increment of the selected voice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this small bank is built from flops rather than RAM, so every entry is reset to a known phase.
      for (int v = 0; v < NUM_VOICES; v++) phase_q[v] <= '0;
    end else if (clear) begin
      for (int v = 0; v < NUM_VOICES; v++) phase_q[v] <= '0;
    end else if (inc_en) begin
      phase_q[inc_sel] <= phase_q[inc_sel] + PHASE_W'(inc_val);
    end
  end

endmodule

// File: rtl/wave_voice_scheduler.sv
// wave_voice_scheduler: shares one external sine ROM across NUM_VOICES voices.
// It sums |sine| over the active voices and advances each voice's phase once per sample.
// Optional build macro WAVE_VOICE_SCHED_PEAK_EN adds the peak_out running-maximum port.
module wave_voice_scheduler
  import wave_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_FRAC = DEFAULT_PHASE_FRAC,
  parameter int SUM_W      = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sample_req,
  input  logic                            phase_clear,
  input  logic [NUM_VOICES-1:0]           voice_active,
  input  logic [FREQ_ID_W*NUM_VOICES-1:0] voice_freq_id,
  output logic [INDEX_W-1:0]              rom_index,
  output logic [FREQ_ID_W-1:0]            rom_freq_id,
  input  logic [VALUE_W-1:0]              rom_value,
  input  logic [FREQ_W-1:0]               rom_freq,
  output logic                            busy,
  output logic                            sample_valid,
  output logic [SUM_W-1:0]                sample_out
`ifdef WAVE_VOICE_SCHED_PEAK_EN
  ,
  output logic [SUM_W-1:0]                peak_out
`endif
);

  localparam int PHASE_W = PHASE_FRAC + 10;
  localparam int VCNT_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  state_t                            state_q, state_d;
  logic [VCNT_W-1:0]                 vcnt_q;
  logic [NUM_VOICES-1:0]             snap_active_q;
  logic [FREQ_ID_W*NUM_VOICES-1:0]   snap_id_q;
  logic [SUM_W-1:0]                  acc_q;
  logic [SUM_W-1:0]                  acc_next;
  logic [PHASE_W-1:0]                cur_phase;
  logic [FREQ_ID_W-1:0]              cur_id;
  logic                              effective;
  logic                              last_voice;

  assign last_voice = (vcnt_q == VCNT_W'(NUM_VOICES - 1));

  voice_phase_bank #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W),
    .INC_W      (FREQ_W),
    .SEL_W      (VCNT_W)
  ) u_phase_bank (
    .clk      (clk),
    .reset    (reset),
    .clear    (phase_clear),
    .rd_sel   (vcnt_q),
    .rd_phase (cur_phase),
    .inc_en   (effective && !phase_clear),
    .inc_sel  (vcnt_q),
    .inc_val  (rom_freq)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: phase_clear forces IDLE, and requests are only seen in IDLE.
  always_comb begin
    // NOTE: assign a default before the case so that no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    if (phase_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (sample_req) state_d = RUN;
        RUN:     if (last_voice) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and ROM addressing for the voice under evaluation, decoded from registers only.
  always_comb begin
    busy        = (state_q == RUN);
    cur_id      = snap_id_q[int'(vcnt_q)*FREQ_ID_W +: FREQ_ID_W];
    rom_freq_id = cur_id;
    rom_index   = {1'b0, cur_phase[PHASE_FRAC +: 10]};
    effective   = (state_q == RUN) && snap_active_q[vcnt_q] &&
                  (cur_id <= FREQ_ID_W'(NUM_KEYS - 1)) && (rom_freq != '0);
    acc_next    = acc_q + (effective ? SUM_W'(rom_value) : '0);
  end

  // Datapath: snapshot on accept, accumulate per voice, publish on the last voice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcnt_q        <= '0;
      snap_active_q <= '0;
      snap_id_q     <= '0;
      acc_q         <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so each register samples the pre-edge values of the others.
      sample_valid <= 1'b0;
      if (phase_clear) begin
        vcnt_q <= '0;
        acc_q  <= '0;
      end else if (state_q == IDLE) begin
        if (sample_req) begin
          snap_active_q <= voice_active;
          snap_id_q     <= voice_freq_id;
          acc_q         <= '0;
          vcnt_q        <= '0;
        end
      end else begin
        acc_q <= acc_next;
        if (last_voice) begin
          sample_out   <= acc_next;
          sample_valid <= 1'b1;
          vcnt_q       <= '0;
        end else begin
          vcnt_q <= vcnt_q + 1'b1;
        end
      end
    end
  end

`ifdef WAVE_VOICE_SCHED_PEAK_EN
  // Peak tracker: the running maximum of published samples, zeroed by phase_clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_out <= '0;
    end else if (phase_clear) begin
      peak_out <= '0;
    end else if (state_q == RUN && last_voice && acc_next > peak_out) begin
      peak_out <= acc_next;
    end
  end
`else
  // Without the peak tracker, no extra state is kept.
`endif

endmodule

// File: tb/tb_wave_voice_scheduler.sv
// Testbench for wave_voice_scheduler.
// The bench supplies the sine ROM itself. A driver updates a sample-level reference model
// and queues the expected results, and a monitor compares them against the DUT outputs.
module tb_wave_voice_scheduler;

  localparam int N  = 4;
  localparam int PF = 8;
  localparam int SW = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic            sample_req;
  logic            phase_clear;
  logic [N-1:0]    voice_active;
  logic [5*N-1:0]  voice_freq_id;
  logic [10:0]     rom_index;
  logic [4:0]      rom_freq_id;
  logic [9:0]      rom_value;
  logic [10:0]     rom_freq;
  logic            busy;
  logic            sample_valid;
  logic [SW-1:0]   sample_out;
`ifdef WAVE_VOICE_SCHED_PEAK_EN
  logic [SW-1:0]   peak_out;
`endif

  always #5 clk = ~clk;

  wave_voice_scheduler #(.NUM_VOICES(N), .PHASE_FRAC(PF), .SUM_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_req    (sample_req),
    .phase_clear   (phase_clear),
    .voice_active  (voice_active),
    .voice_freq_id (voice_freq_id),
    .rom_index     (rom_index),
    .rom_freq_id   (rom_freq_id),
    .rom_value     (rom_value),
    .rom_freq      (rom_freq),
    .busy          (busy),
    .sample_valid  (sample_valid),
    .sample_out    (sample_out)
`ifdef WAVE_VOICE_SCHED_PEAK_EN
    ,
    .peak_out      (peak_out)
`endif
  );

  // Behavioural ROM: value = round(768*|sin|) over 1024 steps; freq = 256 * 2^(id/12) for ids 0..24.
  int rom_val_tbl [1024];
  int freq_tbl    [32];
  assign rom_value = 10'(rom_val_tbl[rom_index[9:0]]);
  assign rom_freq  = 11'(freq_tbl[rom_freq_id]);

  typedef struct { int cyc; int sum; }          exp_t;
  typedef struct { int cyc; int idx; int id; }  rexp_t;

  exp_t  sq [$];
  rexp_t rq [$];
  int    m_phase [N];
  int    last_accept = -1000;
  int    cyc = 0;
  int    exp_peak = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model, evaluated once per clock edge e with the inputs sampled at that edge.
  task automatic model_edge(input int e, input bit req, input bit clr);
    int sum, id, idx;
    if (clr) begin
      for (int v = 0; v < N; v++) m_phase[v] = 0;
      if (e <= last_accept + N && sq.size() > 0) void'(sq.pop_back());
      while (rq.size() > 0 && rq[$].cyc >= e) void'(rq.pop_back());
      exp_peak    = 0;
      last_accept = -1000;
    end else if (req && e >= last_accept + N + 1) begin
      sum = 0;
      for (int v = 0; v < N; v++) begin
        id  = int'(voice_freq_id[5*v +: 5]);
        idx = (m_phase[v] >> PF) % 1024;
        rq.push_back('{cyc: e + v, idx: idx, id: id});
        if (voice_active[v] && id <= 24 && freq_tbl[id] != 0) begin
          sum += rom_val_tbl[idx];
          m_phase[v] = (m_phase[v] + freq_tbl[id]) % (1 << (PF + 10));
        end
      end
      sq.push_back('{cyc: e + N, sum: sum});
      last_accept = e;
    end
  endtask

  // Present one cycle of control inputs, then let the model see the edge that samples them.
  task automatic step(input bit req, input bit clr);
    int e;
    sample_req  = req;
    phase_clear = clr;
    e = cyc + 1;
    @(posedge clk);
    model_edge(e, req, clr);
    #1;
    sample_req  = 1'b0;
    phase_clear = 1'b0;
  endtask

  // Issue one request and idle until the DUT can accept the next one.
  task automatic run_sample();
    step(1'b1, 1'b0);
    repeat (N) step(1'b0, 1'b0);
  endtask

  task automatic set_voice(input int v, input bit act, input int id);
    voice_active[v]          = act;
    voice_freq_id[5*v +: 5]  = 5'(id);
  endtask

  task automatic clear_all();
    voice_active  = '0;
    voice_freq_id = '0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  // Monitor: checks the ROM addressing on every evaluated voice cycle and every published sample.
  always @(negedge clk) begin
    rexp_t r;
    exp_t  x;
    if (!reset) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        check("rom_index",   int'(rom_index),   r.idx);
        check("rom_freq_id", int'(rom_freq_id), r.id);
      end
      if (sample_valid) begin
        if (sq.size() == 0) begin
          check("spurious_sample_valid", int'(sample_valid), 0);
        end else begin
          x = sq.pop_front();
          check("valid_cycle", cyc, x.cyc);
          check("sample_out",  int'(sample_out), x.sum);
`ifdef WAVE_VOICE_SCHED_PEAK_EN
          if (x.sum > exp_peak) exp_peak = x.sum;
          check("peak_out", int'(peak_out), exp_peak);
`endif
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    real s;
    for (int i = 0; i < 1024; i++) begin
      s = $sin(6.283185307179586 * real'(i) / 1024.0);
      if (s < 0.0) s = -s;
      rom_val_tbl[i] = $rtoi(768.0 * s + 0.5);
    end
    for (int i = 0; i < 32; i++)
      freq_tbl[i] = (i <= 24) ? $rtoi(256.0 * (2.0 ** (real'(i) / 12.0)) + 0.5) : 0;
    for (int v = 0; v < N; v++) m_phase[v] = 0;

    reset         = 1'b1;
    sample_req    = 1'b0;
    phase_clear   = 1'b0;
    voice_active  = '0;
    voice_freq_id = '0;
    @(negedge clk);
    check("reset_busy",         int'(busy),         0);
    check("reset_sample_valid", int'(sample_valid), 0);
    check("reset_sample_out",   int'(sample_out),   0);
    check("reset_rom_index",    int'(rom_index),    0);
    check("reset_rom_freq_id",  int'(rom_freq_id),  0);
`ifdef WAVE_VOICE_SCHED_PEAK_EN
    check("reset_peak_out",     int'(peak_out),     0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;

    // Single voice at key 0: index steps by one per sample.
    clear_all();
    set_voice(0, 1'b1, 0);
    repeat (3) run_sample();

    // Single voice at key 12: index steps by two per sample.
    clear_all();
    set_voice(0, 1'b1, 12);
    repeat (3) run_sample();

    // Two voices at keys 0 and 24.
    clear_all();
    set_voice(0, 1'b1, 0);
    set_voice(1, 1'b1, 24);
    repeat (2) run_sample();

    // Wrap-around: key 24 advances four index units per sample, so 256 samples return to index 0.
    clear_all();
    set_voice(0, 1'b1, 24);
    repeat (257) run_sample();

    // An invalid key contributes nothing, and requests while busy are dropped.
    clear_all();
    set_voice(0, 1'b1, 30);
    set_voice(2, 1'b1, 5);
    step(1'b1, 1'b0);
    @(negedge clk);
    check("busy_after_accept", int'(busy), 1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (N) step(1'b0, 1'b0);
    run_sample();

    // Abort at vcnt=2: no sample_valid, busy drops, and the next sample starts from zero phase.
    clear_all();
    set_voice(0, 1'b1, 0);
    set_voice(1, 1'b1, 24);
    repeat (2) run_sample();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    @(negedge clk);
    check("busy_after_clear",  int'(busy),         0);
    check("valid_after_clear", int'(sample_valid), 0);
`ifdef WAVE_VOICE_SCHED_PEAK_EN
    check("peak_after_clear",  int'(peak_out),     0);
`endif
    repeat (N + 2) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (N + 1) step(1'b0, 1'b0);
    run_sample();

    // Randomised traffic, with inputs changing mid-sample.
    for (int i = 0; i < 600; i++) begin
      voice_active  = N'($urandom);
      for (int v = 0; v < N; v++) voice_freq_id[5*v +: 5] = 5'($urandom_range(0, 31));
      step(($urandom % 3) == 0, ($urandom % 60) == 0);
    end

    // Drain the outstanding expectations within a bounded number of cycles.
    for (int i = 0; i < 40 && (sq.size() > 0 || rq.size() > 0); i++) step(1'b0, 1'b0);
    check("drain_samples",  sq.size(), 0);
    check("drain_rom_reqs", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
